// File: rtl/card_hit_decoder_pkg.sv
// Shared card grid geometry and decoder state type. The card renderer and the
// click decoder both take their geometry from here so they cannot drift apart.
package card_hit_decoder_pkg;

  localparam int unsigned GRID_X = 132;  // x of left edge of column 0
  localparam int unsigned GRID_Y = 84;   // y of top edge of row 0
  localparam int unsigned CARD_W = 160;
  localparam int unsigned CARD_H = 120;
  localparam int unsigned GAP    = 40;   // spacing between cards, both axes
  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned ADDR_W = 4;    // COLS*ROWS must fit in 2**ADDR_W
  localparam int unsigned POS_W  = 12;   // mouse coordinate width

  typedef enum logic [2:0] {
    IDLE,
    SCAN_COL,
    SCAN_ROW,
    REPORT,
    MISS,
    WAIT_RELEASE
  } state_t;

endpackage

// File: rtl/card_hit_decoder_axis_scanner.sv
// One-axis hit scanner: walks the card slots of one axis, one slot per cycle,
// and reports whether the latched position falls inside a card span.
module card_hit_decoder_axis_scanner
  import card_hit_decoder_pkg::*;
#(
  parameter int unsigned PW   = POS_W,
  parameter int unsigned IW   = ADDR_W,
  parameter int unsigned STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pos,
  input  logic [PW:0]   origin,
  input  logic [PW:0]   span,
  input  logic [PW:0]   pitch,
  input  logic [IW:0]   count,
  output logic          done,
  output logic          hit,
  output logic [IW-1:0] index
);

  logic          active;
  logic [PW:0]   base;
  logic [IW:0]   slot;
  logic [PW:0]   pos_ext;

  // One extra bit on both sides of the compare so base+span never wraps.
  assign pos_ext = {1'b0, pos};
  assign hit     = active & (pos_ext >= base) & (pos_ext < (base + span));
  assign done    = active & (hit | (slot == (count - (IW + 1)'(1))));

  // Slot walk: index advances by STEP per slot so the row scanner directly
  // yields row*COLS without a multiplier; index is held after done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      base   <= '0;
      slot   <= '0;
      index  <= '0;
    end else if (start) begin
      active <= 1'b1;
      base   <= origin;
      slot   <= '0;
      index  <= '0;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        slot  <= slot + (IW + 1)'(1);
        base  <= base + pitch;
        index <= index + IW'(STEP);
      end
    end
  end

endmodule

// File: rtl/card_hit_decoder.sv
// Turns a left click into the regfile address of the card under the cursor,
// using a column scan followed by a row scan. Emits a one-cycle card_pressed
// or miss pulse, then waits for the button to be released.
module card_hit_decoder
  import card_hit_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  input  logic              left,
  output logic              card_pressed,
  output logic [ADDR_W-1:0] card_address,
  output logic              miss,
  output logic              busy
);

  localparam int unsigned AW = POS_W + 1;

  localparam logic [AW-1:0]     COL_ORIGIN = AW'(GRID_X);
  localparam logic [AW-1:0]     COL_SPAN   = AW'(CARD_W);
  localparam logic [AW-1:0]     COL_PITCH  = AW'(CARD_W + GAP);
  localparam logic [ADDR_W:0]   COL_COUNT  = (ADDR_W + 1)'(COLS);
  localparam logic [AW-1:0]     ROW_ORIGIN = AW'(GRID_Y);
  localparam logic [AW-1:0]     ROW_SPAN   = AW'(CARD_H);
  localparam logic [AW-1:0]     ROW_PITCH  = AW'(CARD_H + GAP);
  localparam logic [ADDR_W:0]   ROW_COUNT  = (ADDR_W + 1)'(ROWS);

  state_t             state;
  logic               left_q;
  logic               armed;
  logic               press;
  logic [POS_W-1:0]   x_l;
  logic [POS_W-1:0]   y_l;
  logic               col_start;
  logic               col_done;
  logic               col_hit;
  logic [ADDR_W-1:0]  col_index;
  logic               row_start;
  logic               row_done;
  logic               row_hit;
  logic [ADDR_W-1:0]  row_index;

  // armed stays low until left has been seen released after reset, so a button
  // already held when reset lifts is not taken as a fresh press.
  assign press     = left & ~left_q & armed;
  assign col_start = (state == IDLE) & press & enable;
  assign row_start = (state == SCAN_COL) & enable & col_hit;
  assign busy      = (state != IDLE);

  card_hit_decoder_axis_scanner #(
    .PW   (POS_W),
    .IW   (ADDR_W),
    .STEP (1)
  ) u_col_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (col_start),
    .pos    (x_l),
    .origin (COL_ORIGIN),
    .span   (COL_SPAN),
    .pitch  (COL_PITCH),
    .count  (COL_COUNT),
    .done   (col_done),
    .hit    (col_hit),
    .index  (col_index)
  );

  // Row index steps by COLS, accumulating row*COLS as the scan proceeds.
  card_hit_decoder_axis_scanner #(
    .PW   (POS_W),
    .IW   (ADDR_W),
    .STEP (COLS)
  ) u_row_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (row_start),
    .pos    (y_l),
    .origin (ROW_ORIGIN),
    .span   (ROW_SPAN),
    .pitch  (ROW_PITCH),
    .count  (ROW_COUNT),
    .done   (row_done),
    .hit    (row_hit),
    .index  (row_index)
  );

  // Control FSM with registered pulse outputs and address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      left_q       <= 1'b0;
      armed        <= 1'b0;
      x_l          <= '0;
      y_l          <= '0;
      card_pressed <= 1'b0;
      miss         <= 1'b0;
      card_address <= '0;
    end else begin
      left_q       <= left;
      armed        <= armed | ~left;
      card_pressed <= 1'b0;
      miss         <= 1'b0;
      case (state)
        IDLE: begin
          if (press && enable) begin
            x_l   <= xpos;
            y_l   <= ypos;
            state <= SCAN_COL;
          end
        end
        SCAN_COL: begin
          if (!enable) begin
            state <= IDLE;
          end else if (col_done) begin
            if (col_hit) begin
              state <= SCAN_ROW;
            end else begin
              state <= MISS;
              miss  <= 1'b1;
            end
          end
        end
        SCAN_ROW: begin
          if (!enable) begin
            state <= IDLE;
          end else if (row_done) begin
            if (row_hit) begin
              state        <= REPORT;
              card_pressed <= 1'b1;
              card_address <= row_index + col_index;
            end else begin
              state <= MISS;
              miss  <= 1'b1;
            end
          end
        end
        REPORT, MISS: begin
          state <= enable ? WAIT_RELEASE : IDLE;
        end
        WAIT_RELEASE: begin
          if (!left) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_hit_decoder.sv
// Directed bench for card_hit_decoder: table of clicks with hand-computed
// address/latency, plus sequences for reset, abort and held-button cases.
module tb_card_hit_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        card_pressed;
  logic [3:0]  card_address;
  logic        miss;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_addr = 0;

  always #5 clk = ~clk;

  card_hit_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .xpos         (xpos),
    .ypos         (ypos),
    .left         (left),
    .card_pressed (card_pressed),
    .card_address (card_address),
    .miss         (miss),
    .busy         (busy)
  );

  typedef struct {
    int x;
    int y;
    bit hit;
    int addr;
    int lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Watch n cycles for any pulse; count pulses seen.
  task automatic quiet(input int n, input string name);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (card_pressed || miss) pulses++;
    end
    chk(name, pulses, 0);
  endtask

  task automatic do_click(input vec_t v, input string name);
    int k = 0;
    bit found = 0;
    bit saw_hit = 0;
    @(negedge clk);
    xpos = 12'(v.x);
    ypos = 12'(v.y);
    left = 1'b1;
    while (k < 20 && !found) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      // Coordinates move after the press; decoder must use latched values.
      xpos = 12'd0;
      ypos = 12'd4095;
      if (card_pressed || miss) begin
        found   = 1;
        saw_hit = card_pressed;
      end
    end
    chk({name, "_pulse_seen"}, int'(found), 1);
    chk({name, "_is_hit"}, int'(saw_hit), int'(v.hit));
    chk({name, "_latency"}, k, v.lat);
    if (v.hit) last_addr = v.addr;
    chk({name, "_addr"}, int'(card_address), last_addr);
    quiet(3, {name, "_single_pulse"});
    chk({name, "_busy_held"}, int'(busy), 1);
    left = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_busy_released"}, int'(busy), 0);
    chk({name, "_addr_stable"}, int'(card_address), last_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Grid: cols start 132,332,532,732 (width 160); rows 84,244,404,564 (h 120)
    vecs[0]  = '{340, 410, 1'b1, 9, 6};    // col1 row2
    vecs[1]  = '{132, 84, 1'b1, 0, 3};     // top-left corner inside
    vecs[2]  = '{291, 84, 1'b1, 0, 3};     // last pixel of col0
    vecs[3]  = '{292, 84, 1'b0, 0, 5};     // gap after col0
    vecs[4]  = '{800, 600, 1'b1, 15, 9};   // col3 row3, worst latency
    vecs[5]  = '{4095, 84, 1'b0, 0, 5};    // beyond grid in x
    vecs[6]  = '{132, 203, 1'b1, 0, 3};    // last row pixel of row0
    vecs[7]  = '{132, 204, 1'b0, 0, 6};    // row gap, miss after row scan
    vecs[8]  = '{691, 363, 1'b1, 6, 6};    // bottom-right of col2 row1
    vecs[9]  = '{131, 84, 1'b0, 0, 5};     // one left of grid
    vecs[10] = '{600, 4095, 1'b1, 0, 8};   // col2 hit, rows exhausted
    vecs[10].hit = 1'b0;

    // Reset with the button held: no decode after reset lifts.
    rst = 1'b0; enable = 1'b1; left = 1'b1; xpos = 12'd340; ypos = 12'd410;
    #12;
    chk("reset_pressed", int'(card_pressed), 0);
    chk("reset_miss", int'(miss), 0);
    chk("reset_addr", int'(card_address), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    quiet(6, "held_after_reset");
    chk("held_after_reset_busy", int'(busy), 0);
    chk("held_after_reset_addr", int'(card_address), 0);
    left = 1'b0;
    quiet(2, "release_after_reset");

    // Table-driven clicks.
    for (int i = 0; i < 11; i++) begin
      do_click(vecs[i], $sformatf("vec%0d", i));
      quiet(1, $sformatf("vec%0d_idle_gap", i));
    end

    // Abort: enable drops in cycle T+3 during the row scan.
    @(negedge clk);
    xpos = 12'd340; ypos = 12'd410; left = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle_t4", int'(busy), 0);
    quiet(8, "abort_no_pulse");
    chk("abort_addr_kept", int'(card_address), last_addr);
    // Re-enable while the button is still held: no decode.
    enable = 1'b1;
    quiet(10, "reenable_held");
    chk("reenable_held_busy", int'(busy), 0);
    left = 1'b0;
    quiet(2, "abort_release");

    // Async reset mid-scan at T+4.
    @(negedge clk);
    xpos = 12'd340; ypos = 12'd410; left = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midscan_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_addr", int'(card_address), 0);
    chk("async_rst_pulses", int'(card_pressed) + int'(miss), 0);
    last_addr = 0;
    @(negedge clk);
    rst = 1'b1;
    quiet(8, "rst_release_held");
    chk("rst_release_held_busy", int'(busy), 0);
    left = 1'b0;
    quiet(2, "rst_release_low");
    do_click('{550, 250, 1'b1, 6, 6}, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
